// File: rtl/lab3_prime_scan_ctrl_if.sv
// Indicator and hit-stream signals shared by the scan sequencer and its neighbours.
// master = sequencer side (drives ind_in and the stream), slave = indicator/consumer side.
interface lab3_prime_scan_ctrl_if;
    logic [3:0] ind_in;
    logic       ind_prime;
    logic [4:0] ind_mul;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;

    modport master (
        output ind_in,
        output out_valid,
        output out_data,
        input  ind_prime,
        input  ind_mul,
        input  out_ready
    );

    modport slave (
        input  ind_in,
        input  out_valid,
        input  out_data,
        output ind_prime,
        output ind_mul,
        output out_ready
    );
endinterface

// File: rtl/lab3_prime_scan_ctrl.sv
// Sweeps the prime/multiplier indicator over [lo,hi] and counts hits.
// Define LAB3_SCAN_STREAM_EN to stream each hit through a one-entry valid/ready buffer.
module lab3_prime_scan_ctrl #(
    parameter int CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [3:0]            lo,
    input  logic [3:0]            hi,
    input  logic                  mode,
    input  logic [2:0]            sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_W-1:0]      hit_cnt,
    lab3_prime_scan_ctrl_if.master scan
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       ind_in_q, ind_in_d;
    logic [3:0]       hi_q, hi_d;
    logic             mode_q, mode_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             err_q, err_d;

    logic             hit;
    logic             buf_free;
    logic             load;
    logic [7:0]       mul_ext;

    // Zero-extended so that sel values 5..7 index a constant 0.
    assign mul_ext = {3'b000, scan.ind_mul};

`ifdef LAB3_SCAN_STREAM_EN
    logic       buf_valid_q, buf_valid_d;
    logic [3:0] buf_data_q, buf_data_d;

    assign buf_free = !buf_valid_q || scan.out_ready;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (buf_valid_q && scan.out_ready) begin
            buf_valid_d = 1'b0;
        end
        if (load) begin
            buf_valid_d = 1'b1;
            buf_data_d  = ind_in_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= 4'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign scan.out_valid = buf_valid_q;
    assign scan.out_data  = buf_data_q;
`else
    logic unused_ready;

    assign unused_ready   = scan.out_ready;
    assign buf_free       = 1'b1;
    assign scan.out_valid = 1'b0;
    assign scan.out_data  = 4'd0;
`endif

    always_comb begin
        state_d   = state_q;
        ind_in_d  = ind_in_q;
        hi_d      = hi_q;
        mode_d    = mode_q;
        sel_d     = sel_q;
        hit_cnt_d = hit_cnt_q;
        err_d     = err_q;
        hit       = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    hit_cnt_d = '0;
                    if (lo <= hi) begin
                        ind_in_d = lo;
                        hi_d     = hi;
                        mode_d   = mode;
                        sel_d    = sel;
                        err_d    = 1'b0;
                        state_d  = SCAN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                hit = mode_q ? mul_ext[sel_q] : scan.ind_prime;
                // A miss never needs the buffer, so only a hit can stall the sweep.
                if (!hit || buf_free) begin
                    if (hit) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                        load      = 1'b1;
                    end
                    if (ind_in_q == hi_q) begin
`ifdef LAB3_SCAN_STREAM_EN
                        state_d = DRAIN;
`else
                        state_d = DONE;
`endif
                    end else begin
                        ind_in_d = ind_in_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (buf_free) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ind_in_q  <= 4'd0;
            hi_q      <= 4'd0;
            mode_q    <= 1'b0;
            sel_q     <= 3'd0;
            hit_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ind_in_q  <= ind_in_d;
            hi_q      <= hi_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            hit_cnt_q <= hit_cnt_d;
            err_q     <= err_d;
        end
    end

    assign scan.ind_in = ind_in_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign hit_cnt     = hit_cnt_q;

endmodule
